// File: rtl/gcd_ctrl.sv
// Moore control FSM for a subtract-and-compare GCD datapath.
// Flags gt/lt/eq come from the datapath; load/select strobes are decoded from state.
module gcd_ctrl #(
  parameter int unsigned             ITER_W   = 16,
  parameter logic [ITER_W-1:0]       MAX_ITER = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              gt,
  input  logic              lt,
  input  logic              eq,
  output logic              lda,
  output logic              ldb,
  output logic              sel1,
  output logic              sel2,
  output logic              selin,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, CMP, SUB_A, SUB_B, DONE, ERR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ITER_W-1:0] r_iter;
  logic              w_one_hot;
  logic              w_accept;

  assign w_one_hot = (gt & ~lt & ~eq) | (~gt & lt & ~eq) | (~gt & ~lt & eq);
  assign w_accept  = start & ((r_state == IDLE) | (r_state == DONE) | (r_state == ERR));
  assign iter_cnt  = r_iter;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_iter  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_iter <= '0;
      else if (((r_state == SUB_A) | (r_state == SUB_B)) && (r_iter != '1))
        r_iter <= r_iter + ITER_W'(1);
    end
  end

  // A matching comparison wins over the iteration limit, so a run that
  // converges on exactly MAX_ITER subtractions still completes.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: if (start) w_next = LOAD_A;
      LOAD_A:          w_next = LOAD_B;
      LOAD_B:          w_next = CMP;
      CMP: begin
        if (!w_one_hot)              w_next = ERR;
        else if (eq)                 w_next = DONE;
        else if (r_iter == MAX_ITER) w_next = ERR;
        else if (gt)                 w_next = SUB_A;
        else                         w_next = SUB_B;
      end
      SUB_A, SUB_B:    w_next = CMP;
      default:         w_next = IDLE;
    endcase
  end

  always_comb begin
    lda   = 1'b0;
    ldb   = 1'b0;
    sel1  = 1'b0;
    sel2  = 1'b0;
    selin = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    err   = 1'b0;
    case (r_state)
      LOAD_A: begin lda = 1'b1; busy = 1'b1; end
      LOAD_B: begin ldb = 1'b1; busy = 1'b1; end
      CMP:    busy = 1'b1;
      SUB_A:  begin lda = 1'b1; selin = 1'b1; sel1 = 1'b1; busy = 1'b1; end
      SUB_B:  begin ldb = 1'b1; selin = 1'b1; sel2 = 1'b1; busy = 1'b1; end
      DONE:   done = 1'b1;
      ERR:    err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Directed bench for gcd_ctrl driving a small behavioural A/B datapath.
module tb_gcd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic        gt, lt, eq;
  logic        lda, ldb, sel1, sel2, selin, busy, done, err;
  logic [15:0] iter_cnt;

  logic [7:0]  dp_a, dp_b, op_a, op_b, w_res;
  logic        force_en, f_gt, f_lt, f_eq;
  logic [7:0]  w_ctl;
  int          n_cmp = 0;
  int          n_err = 0;
  int          edges;
  logic [7:0]  seq [8];

  always #5 clk = ~clk;

  gcd_ctrl #(.ITER_W(16), .MAX_ITER(16'd4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .gt(gt), .lt(lt), .eq(eq),
    .lda(lda), .ldb(ldb), .sel1(sel1), .sel2(sel2), .selin(selin),
    .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt)
  );

  // Datapath model: A/B registers, subtractor and comparator.
  assign w_res = (sel1 ? dp_a : dp_b) - (sel2 ? dp_a : dp_b);
  assign gt    = force_en ? f_gt : (dp_a > dp_b);
  assign lt    = force_en ? f_lt : (dp_a < dp_b);
  assign eq    = force_en ? f_eq : (dp_a == dp_b);
  assign w_ctl = {busy, done, err, lda, ldb, selin, sel1, sel2};

  always @(posedge clk) begin
    if (lda) dp_a <= selin ? w_res : op_a;
    if (ldb) dp_b <= selin ? w_res : op_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns with the bench positioned just after the edge that samples start.
  task automatic start_run(input logic [7:0] a, input logic [7:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_end(output int e);
    e = 0;
    while (!(done || err) && e < 100) begin
      step(1);
      e++;
    end
    if (!(done || err)) chk("timeout", {31'b0, done | err}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; force_en = 1'b0;
    f_gt = 1'b0; f_lt = 1'b0; f_eq = 1'b0;
    op_a = '0; op_b = '0; dp_a = '0; dp_b = '0;
    seq[0] = 8'b1001_0000;  // LOAD_A
    seq[1] = 8'b1000_1000;  // LOAD_B
    seq[2] = 8'b1000_0000;  // CMP
    seq[3] = 8'b1001_0110;  // SUB_A
    seq[4] = 8'b1000_0000;  // CMP
    seq[5] = 8'b1000_1101;  // SUB_B
    seq[6] = 8'b1000_0000;  // CMP
    seq[7] = 8'b0100_0000;  // DONE

    step(2);
    chk("reset_ctl", {24'b0, w_ctl}, 32'd0);
    chk("reset_iter", {16'b0, iter_cnt}, 32'd0);
    rst_n = 1'b1;
    step(2);
    chk("idle_hold_ctl", {24'b0, w_ctl}, 32'd0);

    // 12,8 -> SUB_A, SUB_B, done at edge 7
    start_run(8'd12, 8'd8);
    chk("seq12_8_e0", {24'b0, w_ctl}, {24'b0, seq[0]});
    for (int k = 1; k < 8; k++) begin
      step(1);
      chk($sformatf("seq12_8_e%0d", k), {24'b0, w_ctl}, {24'b0, seq[k]});
    end
    chk("gcd12_8_iter", {16'b0, iter_cnt}, 32'd2);
    chk("gcd12_8_a", {24'b0, dp_a}, 32'd4);
    chk("gcd12_8_b", {24'b0, dp_b}, 32'd4);
    step(2);
    chk("done_hold", {24'b0, w_ctl}, 32'h40);

    // 9,9 -> immediate eq
    start_run(8'd9, 8'd9);
    wait_end(edges);
    chk("eq_latency", edges, 32'd3);
    chk("eq_done", {31'b0, done}, 32'd1);
    chk("eq_iter", {16'b0, iter_cnt}, 32'd0);

    // 5,0 -> gt forever, abort at MAX_ITER=4
    start_run(8'd5, 8'd0);
    wait_end(edges);
    chk("max_latency", edges, 32'd11);
    chk("max_err", {24'b0, w_ctl}, 32'h20);
    chk("max_iter", {16'b0, iter_cnt}, 32'd4);
    step(2);
    chk("err_hold", {24'b0, w_ctl}, 32'h20);
    chk("err_iter_hold", {16'b0, iter_cnt}, 32'd4);

    start_run(8'd6, 8'd4);
    wait_end(edges);
    chk("after_err_latency", edges, 32'd7);
    chk("after_err_ctl", {24'b0, w_ctl}, 32'h40);
    chk("after_err_iter", {16'b0, iter_cnt}, 32'd2);

    // 5,1 converges on exactly MAX_ITER subtractions
    start_run(8'd5, 8'd1);
    wait_end(edges);
    chk("edge_max_latency", edges, 32'd11);
    chk("edge_max_ctl", {24'b0, w_ctl}, 32'h40);
    chk("edge_max_iter", {16'b0, iter_cnt}, 32'd4);

    // gt=lt=1 in CMP -> ERR
    force_en = 1'b1; f_gt = 1'b1; f_lt = 1'b1; f_eq = 1'b0;
    start_run(8'd3, 8'd3);
    wait_end(edges);
    chk("badflag_latency", edges, 32'd3);
    chk("badflag_ctl", {24'b0, w_ctl}, 32'h20);
    force_en = 1'b0;

    // reset mid-run in SUB_B
    start_run(8'd12, 8'd8);
    step(5);
    chk("pre_reset_subb", {24'b0, w_ctl}, {24'b0, seq[5]});
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("midrun_reset_ctl", {24'b0, w_ctl}, 32'd0);
    chk("midrun_reset_iter", {16'b0, iter_cnt}, 32'd0);
    step(2);
    chk("post_reset_idle", {24'b0, w_ctl}, 32'd0);

    // start during busy is ignored
    start_run(8'd12, 8'd8);
    step(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("busy_start_suba", {24'b0, w_ctl}, {24'b0, seq[3]});
    wait_end(edges);
    chk("busy_start_latency", edges, 32'd4);
    chk("busy_start_iter", {16'b0, iter_cnt}, 32'd2);
    step(3);
    chk("busy_start_once", {24'b0, w_ctl}, 32'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gcd_ctrl.md
GCD_CTRL -- requirements
Module: gcd_ctrl

Interface
REQ-001 SHALL have parameter: ITER_W, 16, width of the iteration counter.
REQ-002 SHALL have parameter: MAX_ITER, 16'hFFFF, subtraction count at which the run aborts with error.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: start  input  1  request a new GCD run; level-sampled.
REQ-006 SHALL have ports: gt, lt, eq  input  1 each  datapath A>B, A<B, A==B flags.
REQ-007 SHALL have ports: lda, ldb  output  1 each  load enables for datapath registers A and B.
REQ-008 SHALL have ports: sel1, sel2  output  1 each  subtractor operand selects; 1 selects A, 0 selects B.
REQ-009 SHALL have port: selin  output  1  load-bus select; 1 selects subtractor result, 0 selects external data_in.
REQ-010 SHALL have ports: busy, done, err  output  1 each  run in progress, result valid, run aborted.
REQ-011 SHALL have port: iter_cnt  output  ITER_W  subtractions performed in the current or last run.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, LOAD_A, LOAD_B, CMP, SUB_A, SUB_B, DONE, ERR; all outputs SHALL be registered or decoded from state only.
REQ-013 IDLE, DONE, ERR: start=1 -> LOAD_A and clear iter_cnt to 0; otherwise hold.
REQ-014 LOAD_A: lda=1, selin=0; host SHALL drive operand A on data_in this cycle; -> LOAD_B.
REQ-015 LOAD_B: ldb=1, selin=0; host SHALL drive operand B on data_in this cycle; -> CMP.
REQ-016 CMP: no loads; eq only -> DONE; gt only -> SUB_A; lt only -> SUB_B.
REQ-017 CMP: if not exactly one of gt/lt/eq is high -> ERR.
REQ-018 SUB_A: lda=1, selin=1, sel1=1, sel2=0 (A <= A-B); increment iter_cnt; -> CMP.
REQ-019 SUB_B: ldb=1, selin=1, sel1=0, sel2=1 (B <= B-A); increment iter_cnt; -> CMP.
REQ-020 If iter_cnt equals MAX_ITER while in CMP and eq=0, the FSM SHALL go to ERR instead of SUB_A/SUB_B; iter_cnt SHALL never wrap.
REQ-021 busy=1 in LOAD_A, LOAD_B, CMP, SUB_A, SUB_B; otherwise 0.
REQ-022 done=1 only in DONE; err=1 only in ERR; both SHALL hold until the next accepted start.
REQ-023 Outside LOAD/SUB states: lda=ldb=0, selin=0, sel1=sel2=0.
REQ-024 start while busy SHALL be ignored and SHALL not restart the run.
REQ-025 Latency: done SHALL be high after the (2n+3)th rising edge following the edge that samples start, where n = final iter_cnt.
REQ-026 iter_cnt SHALL hold its final value in DONE/ERR until the next accepted start.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force IDLE, iter_cnt=0, and all control/status outputs 0, from any state including mid-run.
REQ-028 After rst_n returns high, the FSM SHALL stay in IDLE until start=1 is sampled.

Verification
REQ-029 A=12, B=8, start pulse -> state sequence SUB_A, SUB_B; done=1 at edge 7 after start; iter_cnt=2; A=B=4 in datapath.
REQ-030 A=9, B=9 -> CMP sees eq; done at edge 3; iter_cnt=0; no SUB state entered.
REQ-031 MAX_ITER=4, A=5, B=0 -> gt persists; err=1, done=0, iter_cnt=4; new start with A=6, B=4 -> done, iter_cnt=2.
REQ-032 gt=lt=1 forced in CMP -> ERR on next edge, err=1, lda=ldb=0.
REQ-033 rst_n=0 for one edge during SUB_B -> next cycle IDLE, all outputs 0; start then pulsed during busy -> ignored, run completes once.
